// File: rtl/byte_bus_master_pkg.sv
// Shared encodings for the byte-wide bus initiator: access sizes, FSM states
// and the bus data width.
package byte_bus_master_pkg;

  localparam int DATA_W = 8;

  // CPU access size encoding on i_cpu_size.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  // Initiator FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10,
    DONE = 2'b11
  } state_e;

  // Index of the last byte of an access (N-1). Reserved size never reaches
  // the bus, so its value here does not matter.
  function automatic logic [1:0] last_index(input logic [1:0] size);
    case (size)
      SZ_BYTE: last_index = 2'd0;
      SZ_HALF: last_index = 2'd1;
      default: last_index = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/byte_bus_master_load_extend.sv
// Sign/zero extension of an assembled little-endian load result from bit 8N-1.
module byte_bus_master_load_extend
  import byte_bus_master_pkg::*;
(
  input  logic [31:0] i_data,
  input  logic [1:0]  i_size,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  // Pick the extension width from the access size; words pass straight through.
  always_comb begin
    o_data = i_data;
    case (i_size)
      SZ_BYTE: o_data = {{24{~i_unsigned & i_data[7]}}, i_data[7:0]};
      SZ_HALF: o_data = {{16{~i_unsigned & i_data[15]}}, i_data[15:0]};
      default: o_data = i_data;
    endcase
  end

endmodule

// File: rtl/byte_bus_master.sv
// Byte-wide peripheral bus initiator. Turns one CPU load/store of 1, 2 or 4
// bytes into sequential single-byte bus transactions and assembles the
// little-endian load result.
//
// Handshakes:
//   CPU side: i_cpu_req is a start pulse accepted only while o_cpu_busy is low
//   (IDLE); requests while busy are dropped, not queued. Completion is the
//   one-cycle o_cpu_done pulse; o_cpu_error/o_cpu_rdata are valid with it and
//   hold until the next completion.
//   Bus side: o_bus_request is a one-cycle pulse per byte; address/write/data
//   stay stable until the responder answers with a single i_bus_data_DV cycle,
//   which also qualifies i_bus_data for reads. DV outside WAIT is ignored.
module byte_bus_master
  import byte_bus_master_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [31:0]       i_cpu_wdata,
  input  logic [1:0]        i_cpu_size,
  input  logic              i_cpu_unsigned,
  output logic              o_cpu_busy,
  output logic              o_cpu_done,
  output logic              o_cpu_error,
  output logic [31:0]       o_cpu_rdata,
  output logic              o_bus_request,
  output logic              o_bus_write,
  output logic [ADDR_W-1:0] o_bus_address,
  output logic [DATA_W-1:0] o_bus_data,
  input  logic [DATA_W-1:0] i_bus_data,
  input  logic              i_bus_data_DV,
  output logic [1:0]        o_dbg_state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic [1:0]          k_q, k_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [31:0]         acc_q, acc_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                error_q, error_d;

  logic [31:0]         acc_merged;
  logic [31:0]         ext_data;
  logic [DATA_W-1:0]   wbyte;
  logic [ADDR_W-1:0]   cur_addr;

  // Current byte address (wraps modulo 2^ADDR_W) and byte k of the store data.
  always_comb begin
    cur_addr   = addr_q + ADDR_W'(k_q);
    wbyte      = wdata_q[7:0];
    acc_merged = acc_q;
    case (k_q)
      2'd0: begin wbyte = wdata_q[7:0];   acc_merged[7:0]   = i_bus_data; end
      2'd1: begin wbyte = wdata_q[15:8];  acc_merged[15:8]  = i_bus_data; end
      2'd2: begin wbyte = wdata_q[23:16]; acc_merged[23:16] = i_bus_data; end
      default: begin wbyte = wdata_q[31:24]; acc_merged[31:24] = i_bus_data; end
    endcase
  end

  // Extension uses the merged accumulator so the final byte lands in the
  // result on the same edge that enters DONE.
  byte_bus_master_load_extend u_load_extend (
    .i_data     (acc_merged),
    .i_size     (size_q),
    .i_unsigned (uns_q),
    .o_data     (ext_data)
  );

  // Next-state and output logic for the IDLE/REQ/WAIT/DONE sequencer.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    size_d        = size_q;
    uns_d         = uns_q;
    k_d           = k_q;
    cnt_d         = cnt_q;
    acc_d         = acc_q;
    rdata_d       = rdata_q;
    error_d       = error_q;
    o_cpu_done    = 1'b0;
    o_bus_request = 1'b0;
    o_bus_write   = 1'b0;
    o_bus_address = '0;
    o_bus_data    = '0;

    case (state_q)
      IDLE: begin
        if (i_cpu_req) begin
          we_d    = i_cpu_we;
          addr_d  = i_cpu_addr;
          wdata_d = i_cpu_wdata;
          size_d  = i_cpu_size;
          uns_d   = i_cpu_unsigned;
          k_d     = 2'd0;
          acc_d   = '0;
          if (i_cpu_size == SZ_RSVD) begin
            error_d = 1'b1;
            rdata_d = '0;
            state_d = DONE;
          end else begin
            state_d = REQ;
          end
        end
      end

      REQ: begin
        o_bus_request = 1'b1;
        o_bus_write   = we_q;
        o_bus_address = cur_addr;
        o_bus_data    = wbyte;
        cnt_d         = '0;
        state_d       = WAIT;
      end

      WAIT: begin
        // Address/write/data held: responder read data is combinational on address.
        o_bus_write   = we_q;
        o_bus_address = cur_addr;
        o_bus_data    = wbyte;
        if (i_bus_data_DV) begin
          if (!we_q) acc_d = acc_merged;
          if (k_q == last_index(size_q)) begin
            error_d = 1'b0;
            rdata_d = we_q ? 32'd0 : ext_data;
            state_d = DONE;
          end else begin
            k_d     = k_q + 2'd1;
            state_d = REQ;
          end
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          // Abort: remaining bytes are not issued, written bytes stay written.
          error_d = 1'b1;
          rdata_d = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        o_cpu_done = 1'b1;
        state_d    = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset also abandons an in-flight access.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      k_q     <= '0;
      cnt_q   <= '0;
      acc_q   <= '0;
      rdata_q <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      k_q     <= k_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      rdata_q <= rdata_d;
      error_q <= error_d;
    end
  end

  assign o_cpu_busy  = (state_q != IDLE);
  assign o_cpu_error = error_q;
  assign o_cpu_rdata = rdata_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_byte_bus_master.sv
// Directed bench for byte_bus_master against a byte-addressed responder model
// (hex display register block plus plain memory behind it).
module tb_byte_bus_master;

  localparam int ADDR_W = 12;

  logic              clk = 1'b0;
  logic              rst;
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [31:0]       cpu_wdata;
  logic [1:0]        cpu_size;
  logic              cpu_uns;
  logic              o_cpu_busy;
  logic              o_cpu_done;
  logic              o_cpu_error;
  logic [31:0]       o_cpu_rdata;
  logic              o_bus_request;
  logic              o_bus_write;
  logic [ADDR_W-1:0] o_bus_address;
  logic [7:0]        o_bus_data;
  logic [7:0]        bus_rdata;
  logic              bus_dv;
  logic [1:0]        dbg_state;

  // Responder model
  logic [7:0]        mem [4096] = '{default: 8'h00};
  logic              resp_en;
  logic              dv_q;
  logic              spur_dv;
  logic [ADDR_W-1:0] addr_log [$];

  int n_assert = 0;
  int n_fail   = 0;

  byte_bus_master #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
    .i_clk          (clk),
    .i_reset        (rst),
    .i_cpu_req      (cpu_req),
    .i_cpu_we       (cpu_we),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_wdata    (cpu_wdata),
    .i_cpu_size     (cpu_size),
    .i_cpu_unsigned (cpu_uns),
    .o_cpu_busy     (o_cpu_busy),
    .o_cpu_done     (o_cpu_done),
    .o_cpu_error    (o_cpu_error),
    .o_cpu_rdata    (o_cpu_rdata),
    .o_bus_request  (o_bus_request),
    .o_bus_write    (o_bus_write),
    .o_bus_address  (o_bus_address),
    .o_bus_data     (o_bus_data),
    .i_bus_data     (bus_rdata),
    .i_bus_data_DV  (bus_dv),
    .o_dbg_state    (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  // Responder: DV one cycle after each request, read data combinational on address.
  assign bus_rdata = mem[o_bus_address];
  assign bus_dv    = dv_q | spur_dv;

  always @(posedge clk) begin
    if (rst) begin
      dv_q <= 1'b0;
    end else begin
      dv_q <= o_bus_request & resp_en;
      if (o_bus_request & o_bus_write & resp_en) mem[o_bus_address] <= o_bus_data;
    end
    if (o_bus_request) addr_log.push_back(o_bus_address);
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required completion earlier", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one CPU access and wait (bounded) for the done pulse.
  // done_cyc counts cycles after the req edge; cycle 1 is the first after it.
  task automatic do_op(input logic we, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                       input logic [1:0] size, input logic uns, input bit spur,
                       output int done_cyc, output logic [31:0] rdata, output logic err);
    @(negedge clk);
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_size  = size;
    cpu_uns   = uns;
    cpu_req   = 1'b1;
    if (spur) spur_dv = 1'b1;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    done_cyc = -1;
    rdata    = '0;
    err      = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 2) spur_dv = 1'b0;
      if (o_cpu_done) begin
        done_cyc = c;
        rdata    = o_cpu_rdata;
        err      = o_cpu_error;
        break;
      end
    end
    spur_dv = 1'b0;
  endtask

  initial begin
    int          dc;
    logic [31:0] rd;
    logic        er;
    logic        seen_done;

    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    cpu_size = 2'b00; cpu_uns = 1'b0; resp_en = 1'b1; spur_dv = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", {31'd0, o_cpu_busy}, 32'd0);
    check("rst_done", {31'd0, o_cpu_done}, 32'd0);
    check("rst_error", {31'd0, o_cpu_error}, 32'd0);
    check("rst_rdata", o_cpu_rdata, 32'd0);
    check("rst_request", {31'd0, o_bus_request}, 32'd0);
    check("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b0;

    // Word store to the hex display
    addr_log.delete();
    do_op(1'b1, 12'h000, 32'hDEADBEEF, 2'b10, 1'b0, 1'b0, dc, rd, er);
    check("st_word_cycle", 32'(dc), 32'd9);
    check("st_word_err", {31'd0, er}, 32'd0);
    check("st_word_rdata", rd, 32'd0);
    check("st_word_display", {mem[3], mem[2], mem[1], mem[0]}, 32'hDEADBEEF);
    check("st_word_nreq", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      check("st_word_a0", 32'(addr_log[0]), 32'h000);
      check("st_word_a3", 32'(addr_log[3]), 32'h003);
    end

    // Loads with extension
    do_op(1'b0, 12'h003, 32'd0, 2'b00, 1'b0, 1'b0, dc, rd, er);
    check("ld_byte_s_cycle", 32'(dc), 32'd3);
    check("ld_byte_s", rd, 32'hFFFFFFDE);
    check("ld_byte_s_err", {31'd0, er}, 32'd0);
    @(negedge clk);
    check("ld_byte_s_hold", o_cpu_rdata, 32'hFFFFFFDE);
    check("ld_byte_s_pulse", {31'd0, o_cpu_done}, 32'd0);
    do_op(1'b0, 12'h003, 32'd0, 2'b00, 1'b1, 1'b0, dc, rd, er);
    check("ld_byte_u", rd, 32'h000000DE);
    do_op(1'b0, 12'h002, 32'd0, 2'b01, 1'b0, 1'b0, dc, rd, er);
    check("ld_half_s", rd, 32'hFFFFDEAD);
    check("ld_half_s_cycle", 32'(dc), 32'd5);
    do_op(1'b0, 12'h000, 32'd0, 2'b01, 1'b0, 1'b0, dc, rd, er);
    check("ld_half_s_pos", rd, 32'hFFFFBEEF);
    do_op(1'b0, 12'h001, 32'd0, 2'b01, 1'b1, 1'b0, dc, rd, er);
    check("ld_half_u_unal", rd, 32'h0000ADBE);
    do_op(1'b0, 12'h000, 32'd0, 2'b10, 1'b0, 1'b0, dc, rd, er);
    check("ld_word", rd, 32'hDEADBEEF);
    check("ld_word_cycle", 32'(dc), 32'd9);

    // Timeout: responder silent
    mem[5] = 8'h80;
    resp_en = 1'b0;
    addr_log.delete();
    do_op(1'b0, 12'h005, 32'd0, 2'b00, 1'b0, 1'b0, dc, rd, er);
    check("to_cycle", 32'(dc), 32'd18);
    check("to_err", {31'd0, er}, 32'd1);
    check("to_rdata", rd, 32'd0);
    check("to_nreq", 32'(addr_log.size()), 32'd1);
    resp_en = 1'b1;

    // Reserved size
    addr_log.delete();
    do_op(1'b0, 12'h000, 32'd0, 2'b11, 1'b0, 1'b0, dc, rd, er);
    check("rsvd_cycle", 32'(dc), 32'd1);
    check("rsvd_err", {31'd0, er}, 32'd1);
    check("rsvd_nreq", 32'(addr_log.size()), 32'd0);

    // Successful op after error clears the error flag
    do_op(1'b0, 12'h002, 32'd0, 2'b00, 1'b1, 1'b0, dc, rd, er);
    check("post_err_err", {31'd0, er}, 32'd0);
    check("post_err_rdata", rd, 32'h000000AD);

    // Address wrap
    mem[12'hFFE] = 8'h11;
    mem[12'hFFF] = 8'h22;
    addr_log.delete();
    do_op(1'b0, 12'hFFE, 32'd0, 2'b10, 1'b0, 1'b0, dc, rd, er);
    check("wrap_rdata", rd, 32'hBEEF2211);
    check("wrap_nreq", 32'(addr_log.size()), 32'd4);
    if (addr_log.size() == 4) begin
      check("wrap_a0", 32'(addr_log[0]), 32'hFFE);
      check("wrap_a1", 32'(addr_log[1]), 32'hFFF);
      check("wrap_a2", 32'(addr_log[2]), 32'h000);
      check("wrap_a3", 32'(addr_log[3]), 32'h001);
    end

    // Reset in the WAIT of the second byte of a word store
    @(negedge clk);
    cpu_we = 1'b1; cpu_addr = 12'h010; cpu_wdata = 32'h12345678; cpu_size = 2'b10;
    cpu_uns = 1'b0; cpu_req = 1'b1;
    @(posedge clk);
    #1 cpu_req = 1'b0;
    repeat (4) @(negedge clk);
    check("mid_state_wait", {30'd0, dbg_state}, 32'd2);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_request", {31'd0, o_bus_request}, 32'd0);
    check("mid_rst_busy", {31'd0, o_cpu_busy}, 32'd0);
    check("mid_rst_rdata", o_cpu_rdata, 32'd0);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      seen_done = seen_done | o_cpu_done;
    end
    check("mid_no_done", {31'd0, seen_done}, 32'd0);
    check("mid_byte0", {24'd0, mem[12'h010]}, 32'h78);
    check("mid_byte1", {24'd0, mem[12'h011]}, 32'h56);
    check("mid_byte2", {24'd0, mem[12'h012]}, 32'h00);

    // Spurious DV while idle
    spur_dv = 1'b1;
    repeat (2) @(negedge clk);
    check("spur_idle_busy", {31'd0, o_cpu_busy}, 32'd0);
    check("spur_idle_done", {31'd0, o_cpu_done}, 32'd0);
    spur_dv = 1'b0;

    // Spurious DV across IDLE and REQ must not shorten the access
    do_op(1'b0, 12'h011, 32'd0, 2'b00, 1'b1, 1'b1, dc, rd, er);
    check("spur_req_cycle", 32'(dc), 32'd3);
    check("spur_req_rdata", rd, 32'h00000056);

    // New store after reset completes normally
    do_op(1'b1, 12'h020, 32'hCAFE0123, 2'b10, 1'b0, 1'b0, dc, rd, er);
    check("after_rst_cycle", 32'(dc), 32'd9);
    check("after_rst_err", {31'd0, er}, 32'd0);
    check("after_rst_mem", {mem[12'h023], mem[12'h022], mem[12'h021], mem[12'h020]}, 32'hCAFE0123);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
